// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder between
// two requesters. Operands are registered toward the adder, held for SETTLE
// cycles, then the adder outputs are captured and the owner is acknowledged.
module adder_arbiter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SETTLE = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    output logic [WIDTH-1:0] ADD_A,
    output logic [WIDTH-1:0] ADD_B,
    input  logic [WIDTH-1:0] ADD_S,
    input  logic             ADD_C,
    input  logic             ADD_OVF,
    output logic [WIDTH-1:0] RES,
    output logic             RES_CO,
    output logic             RES_OVF,
    output logic             ACK0,
    output logic             ACK1,
    output logic             BUSY
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [3:0] CntInit = 4'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             res_co_q, res_co_d;
    logic             res_ovf_q, res_ovf_d;
    logic             grant;

    // Tie goes to the requester not served last; a lone request always wins.
    assign grant = (REQ0 && REQ1) ? ~last_q : REQ1;

    // Next-state logic: grant in idle, count down the settle time, capture, acknowledge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        res_d     = res_q;
        res_co_d  = res_co_q;
        res_ovf_d = res_ovf_q;
        case (state_q)
            StIdle: begin
                if (REQ0 || REQ1) begin
                    state_d = StRun;
                    owner_d = grant;
                    add_a_d = grant ? A1 : A0;
                    add_b_d = grant ? B1 : B0;
                    cnt_d   = CntInit;
                end
            end
            StRun: begin
                if (cnt_q == 4'd0) begin
                    res_d     = ADD_S;
                    res_co_d  = ADD_C;
                    res_ovf_d = ADD_OVF;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                last_d  = owner_q;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; last-served resets to 1 so requester 0 wins first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            add_a_q   <= '0;
            add_b_q   <= '0;
            res_q     <= '0;
            res_co_q  <= 1'b0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            res_q     <= res_d;
            res_co_q  <= res_co_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign ADD_A   = add_a_q;
    assign ADD_B   = add_b_q;
    assign RES     = res_q;
    assign RES_CO  = res_co_q;
    assign RES_OVF = res_ovf_q;
    assign ACK0    = (state_q == StDone) && !owner_q;
    assign ACK1    = (state_q == StDone) && owner_q;
    assign BUSY    = (state_q != StIdle);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: SETTLE=4 main instance and a SETTLE=1 instance,
// each driving an ideal behavioural 8-bit adder.
module tb_adder_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Main instance (SETTLE=4)
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [7:0] add_a, add_b, add_s, res;
    logic       add_c, add_ovf, res_co, res_ovf, ack0, ack1, busy;

    // SETTLE=1 instance
    logic       r0b = 1'b0;
    logic       r1b = 1'b0;
    logic [7:0] a0b = '0, b0b = '0, zb = '0;
    logic [7:0] add_a_b, add_b_b, add_s_b, res_b, sum_b;
    logic       add_c_b, add_ovf_b, res_co_b, res_ovf_b, ack0_b, ack1_b, busy_b;
    logic       ovr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Ideal adder for the main instance.
    always_comb begin
        {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b};
        add_ovf = (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
    end

    // Ideal adder for the SETTLE=1 instance; ovr corrupts the sum after capture.
    always_comb begin
        {add_c_b, sum_b} = {1'b0, add_a_b} + {1'b0, add_b_b};
        add_ovf_b = (add_a_b[7] == add_b_b[7]) && (sum_b[7] != add_a_b[7]);
        add_s_b = sum_b ^ (ovr ? 8'hFF : 8'h00);
    end

    adder_arbiter #(.WIDTH(8), .SETTLE(4)) u_dut (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .A0(a0), .B0(b0),
        .REQ1(req1), .A1(a1), .B1(b1),
        .ADD_A(add_a), .ADD_B(add_b),
        .ADD_S(add_s), .ADD_C(add_c), .ADD_OVF(add_ovf),
        .RES(res), .RES_CO(res_co), .RES_OVF(res_ovf),
        .ACK0(ack0), .ACK1(ack1), .BUSY(busy)
    );

    adder_arbiter #(.WIDTH(8), .SETTLE(1)) u_dut1 (
        .CLK(clk), .RST(rst),
        .REQ0(r0b), .A0(a0b), .B0(b0b),
        .REQ1(r1b), .A1(zb), .B1(zb),
        .ADD_A(add_a_b), .ADD_B(add_b_b),
        .ADD_S(add_s_b), .ADD_C(add_c_b), .ADD_OVF(add_ovf_b),
        .RES(res_b), .RES_CO(res_co_b), .RES_OVF(res_ovf_b),
        .ACK0(ack0_b), .ACK1(ack1_b), .BUSY(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until either ACK is seen (bounded), counting edges and idle cycles.
    task automatic wait_ack(output int lat, output int idle, output logic g0, output logic g1);
        lat  = 0;
        idle = 0;
        g0   = 1'b0;
        g1   = 1'b0;
        while (!(g0 || g1) && lat < 30) begin
            tick();
            lat++;
            if (!busy) idle++;
            g0 = ack0;
            g1 = ack1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_add_a"}, add_a, 0);
        check({tag, "_add_b"}, add_b, 0);
        check({tag, "_res"}, res, 0);
        check({tag, "_co"}, res_co, 0);
        check({tag, "_ovf"}, res_ovf, 0);
        check({tag, "_ack0"}, ack0, 0);
        check({tag, "_ack1"}, ack1, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int   lat, idle;
        logic g0, g1;

        // Reset state
        tick();
        tick();
        check_zero("rst");
        rst = 1'b0;

        // Requester 0 alone: 43 + 101 = 144, signed overflow
        req0 = 1'b1; a0 = 8'd43; b0 = 8'd101;
        wait_ack(lat, idle, g0, g1);
        check("t1_lat", lat, 5);
        check("t1_ack0", g0, 1);
        check("t1_ack1", g1, 0);
        check("t1_res", res, 8'h90);
        check("t1_co", res_co, 0);
        check("t1_ovf", res_ovf, 1);
        check("t1_idle", idle, 0);
        check("t1_add_a", add_a, 8'd43);
        req0 = 1'b0;
        tick();
        check("t1_busy_after", busy, 0);
        check("t1_add_b_hold", add_b, 8'd101);

        // Requester 1 alone: 0x9E + 0xF2 = 0x190
        req1 = 1'b1; a1 = 8'h9E; b1 = 8'hF2;
        wait_ack(lat, idle, g0, g1);
        check("t2_lat", lat, 5);
        check("t2_ack0", g0, 0);
        check("t2_ack1", g1, 1);
        check("t2_res", res, 8'h90);
        check("t2_co", res_co, 1);
        check("t2_ovf", res_ovf, 0);
        req1 = 1'b0;
        tick();

        // Simultaneous requests right after reset
        rst = 1'b1;
        tick();
        check_zero("rst2");
        rst  = 1'b0;
        req0 = 1'b1; a0 = 8'h12; b0 = 8'h8F;
        req1 = 1'b1; a1 = 8'h01; b1 = 8'h01;
        wait_ack(lat, idle, g0, g1);
        check("t3a_lat", lat, 5);
        check("t3a_ack0", g0, 1);
        check("t3a_ack1", g1, 0);
        check("t3a_res", res, 8'hA1);
        check("t3a_co", res_co, 0);
        check("t3a_ovf", res_ovf, 0);
        req0 = 1'b0;
        wait_ack(lat, idle, g0, g1);
        check("t3b_lat", lat, 6);
        check("t3b_ack1", g1, 1);
        check("t3b_ack0", g0, 0);
        check("t3b_res", res, 8'h02);
        req1 = 1'b0;
        tick();

        // Both held for four operations: strict alternation starting with requester 0
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(lat, idle, g0, g1);
            check($sformatf("t4_ack1_%0d", k), g1, (k % 2));
            check($sformatf("t4_ack0_%0d", k), g0, ((k + 1) % 2));
            check($sformatf("t4_res_%0d", k), res, (k % 2 == 1) ? 8'h02 : 8'hA1);
            if (k > 0) begin
                check($sformatf("t4_lat_%0d", k), lat, 6);
                check($sformatf("t4_idle_%0d", k), idle, 1);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        // Reset pulse during RUN aborts, then the held request restarts
        req0 = 1'b1; a0 = 8'd43; b0 = 8'd101;
        tick();
        tick();
        check("t5_busy_run", busy, 1);
        rst = 1'b1;
        tick();
        check_zero("t5_rst");
        rst = 1'b0;
        wait_ack(lat, idle, g0, g1);
        check("t5_lat", lat, 5);
        check("t5_ack0", g0, 1);
        check("t5_res", res, 8'h90);
        req0 = 1'b0;
        tick();

        // SETTLE=1: ACK at n+2 and result immune to later adder changes
        r0b = 1'b1; a0b = 8'h05; b0b = 8'h07;
        tick();
        check("t6_ack_n1", ack0_b, 0);
        check("t6_busy_n1", busy_b, 1);
        tick();
        check("t6_ack_n2", ack0_b, 1);
        check("t6_ack1", ack1_b, 0);
        check("t6_res", res_b, 8'h0C);
        check("t6_co", res_co_b, 0);
        check("t6_ovf", res_ovf_b, 0);
        ovr = 1'b1;
        r0b = 1'b0;
        tick();
        check("t6_res_hold1", res_b, 8'h0C);
        check("t6_ack_off", ack0_b, 0);
        check("t6_busy_off", busy_b, 0);
        tick();
        check("t6_res_hold2", res_b, 8'h0C);
        check("t6_co_hold", res_co_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
